y86_fetch_sequencer: RTL and testbench

//  Sequences instruction fetch for the y86 decode stage. Reads program bytes one at a time from a

---
 rtl/y86_pkg.sv | 21 ++
 rtl/y86_instr_len.sv | 22 ++
 rtl/y86_fetch_sequencer.sv | 157 +++++++++++++++
 tb/tb_y86_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared y86 definitions: instruction codes, fetch word width and fetch FSM states.
package y86_pkg;

  localparam int INSTR_W = 80;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {FETCH0, FETCHN, PRESENT, HALT} fetch_state_e;

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction length decode from icode; err flags icodes above POPQ.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       err_o
);

  always_comb begin
    len_o = 4'd1;
    err_o = 1'b0;
    case (icode_i)
      ICODE_HALT, ICODE_NOP, ICODE_RET:                len_o = 4'd1;
      ICODE_RRMOVQ, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: len_o = 4'd2;
      ICODE_JXX, ICODE_CALL:                           len_o = 4'd9;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:        len_o = 4'd10;
      default:                                         err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_fetch_sequencer.sv
// Byte-serial y86 instruction fetch: packs 1/2/9/10-byte instructions and presents them to decode.
// Define FETCH_PERF_EN to add the perf_instr / perf_stall counter ports.
module y86_fetch_sequencer
  import y86_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_rvalid,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [3:0]         instr_len,
  output logic               instr_err,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_instr,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, mem_addr_q;
  logic [3:0]         cnt_q, len_q, len_w;
  logic [INSTR_W-1:0] instr_q;
  logic               err_q, err_w, instr_valid_q, halted_q, mem_req_q, drop_q;

  y86_instr_len u_len (
    .icode_i (mem_rdata[7:4]),
    .len_o   (len_w),
    .err_o   (err_w)
  );

  // Valid/ready: instr and sideband hold while instr_valid && !instr_ready;
  // the word transfers on a cycle where both are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH0;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      cnt_q         <= '0;
      len_q         <= '0;
      err_q         <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      mem_req_q     <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      // A response with no request outstanding is either the dropped one or stray.
      if (mem_rvalid && !mem_req_q) drop_q <= 1'b0;
      if (redirect_valid) begin
        state_q       <= FETCH0;
        pc_q          <= redirect_pc;
        mem_addr_q    <= redirect_pc;
        instr_valid_q <= 1'b0;
        halted_q      <= 1'b0;
        mem_req_q     <= 1'b0;
        if (mem_req_q && !mem_rvalid) drop_q <= 1'b1;
      end else begin
        case (state_q)
          FETCH0: begin
            if (mem_req_q) begin
              if (mem_rvalid) begin
                instr_q    <= {mem_rdata, {(INSTR_W-8){1'b0}}};
                len_q      <= len_w;
                err_q      <= err_w;
                cnt_q      <= 4'd1;
                mem_addr_q <= pc_q + ADDR_W'(1);
                if (len_w == 4'd1 || err_w) begin
                  mem_req_q     <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= PRESENT;
                end else begin
                  state_q <= FETCHN;
                end
              end
            end else if (!drop_q || mem_rvalid) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_q;
            end
          end
          FETCHN: begin
            if (mem_rvalid) begin
              for (int k = 1; k < 10; k++) begin
                if (cnt_q == 4'(k)) instr_q[INSTR_W-1-8*k -: 8] <= mem_rdata;
              end
              if (cnt_q == len_q - 4'd1) begin
                mem_req_q     <= 1'b0;
                instr_valid_q <= 1'b1;
                state_q       <= PRESENT;
              end else begin
                cnt_q      <= cnt_q + 4'd1;
                mem_addr_q <= pc_q + ADDR_W'(cnt_q + 4'd1);
              end
            end
          end
          PRESENT: begin
            if (instr_ready) begin
              instr_valid_q <= 1'b0;
              pc_q          <= pc_q + ADDR_W'(len_q);
              if (instr_q[INSTR_W-1 -: 4] == ICODE_HALT || err_q) begin
                halted_q <= 1'b1;
                state_q  <= HALT;
              end else begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc_q + ADDR_W'(len_q);
                state_q    <= FETCH0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;
  assign instr_len   = len_q;
  assign instr_err   = err_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign dbg_state   = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (instr_valid_q && instr_ready && perf_instr_q != 32'hFFFF_FFFF)
        perf_instr_q <= perf_instr_q + 32'd1;
      if (instr_valid_q && !instr_ready && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_y86_fetch_sequencer.sv
// Directed bench for y86_fetch_sequencer with a zero-wait byte memory model.
module tb_y86_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_rvalid, redirect_valid, instr_err, instr_valid, instr_ready, halted;
  logic [63:0] mem_addr, redirect_pc, instr_pc, last_rd_addr;
  logic [7:0]  mem_rdata;
  logic [79:0] instr, held_instr;
  logic [3:0]  instr_len;
  logic [1:0]  dbg_state;
  logic        mem_en, stray_rv, seen_bad;
  logic [7:0]  mem [0:255];
  int          n_tests = 0, n_fail = 0, reads = 0, accepts = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_instr, perf_stall, stall0;
`endif

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rvalid = (mem_req && mem_en) || stray_rv;

  always @(posedge clk) if (mem_req && mem_rvalid) begin
    reads++;
    last_rd_addr = mem_addr;
  end
  always @(negedge clk) if (instr_valid && instr_pc == 64'h40) seen_bad = 1'b1;

  y86_fetch_sequencer dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_len(instr_len), .instr_err(instr_err),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
    .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
    , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, instr_valid, 1'b1);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    accepts++;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin
      if (instr_valid) accept();
      else @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, halted, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_en = 1'b1; stray_rv = 1'b0; seen_bad = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    // T1: reset state, then nop, halt at 0
    mem[0] = 8'h10; mem[1] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", mem_req, 1'b0);
    check("rst_addr", mem_addr, 64'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_instr", instr, 80'h0);
    rst = 1'b0;
    wait_valid("t1a");
    check("t1_nop_instr", instr, {8'h10, 72'h0});
    check("t1_nop_len", instr_len, 4'd1);
    check("t1_nop_pc", instr_pc, 64'h0);
    accept();
    wait_valid("t1b");
    check("t1_halt_instr", instr, 80'h0);
    check("t1_halt_pc", instr_pc, 64'h1);
    accept();
    check("t1_halted", halted, 1'b1);
    check("t1_req_off", mem_req, 1'b0);

    // T2: irmovq at 0x20
    mem[8'h20] = 8'h30; mem[8'h21] = 8'hF3; mem[8'h22] = 8'h0D;
    mem[8'h2A] = 8'h00;
    reads = 0;
    redirect(64'h20);
    wait_valid("t2");
    check("t2_instr", instr, 80'h30F30D00000000000000);
    check("t2_len", instr_len, 4'd10);
    check("t2_pc", instr_pc, 64'h20);
    check("t2_reads", reads, 10);
    accept();
    check("t2_next_addr", mem_addr, 64'h2A);
    check("t2_next_req", mem_req, 1'b1);
    run_to_halt("t2");

    // T3: rrmovq held 5 cycles
    mem[8'h30] = 8'h20; mem[8'h31] = 8'h12; mem[8'h32] = 8'h00;
    redirect(64'h30);
    wait_valid("t3");
    held_instr = instr;
`ifdef FETCH_PERF_EN
    stall0 = perf_stall;
`endif
    check("t3_instr", held_instr, {8'h20, 8'h12, 64'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_instr", instr, {8'h20, 8'h12, 64'h0});
      check("t3_hold_valid", instr_valid, 1'b1);
    end
    check("t3_hold_len", instr_len, 4'd2);
    check("t3_hold_pc", instr_pc, 64'h30);
`ifdef FETCH_PERF_EN
    check("t3_perf_stall", perf_stall - stall0, 32'd5);
`endif
    accept();
    run_to_halt("t3");

    // T4: redirect while byte 4 of a 9-byte jmp is outstanding
    mem[8'h40] = 8'h70;
    for (int i = 1; i < 9; i++) mem[8'h40 + i] = 8'(8'h50 + i);
    mem[0] = 8'h00;
    seen_bad = 1'b0;
    redirect(64'h40);
    for (int n = 0; n < 50 && !(mem_req && mem_addr == 64'h44); n++) @(negedge clk);
    mem_en = 1'b0;
    check("t4_at_byte4", mem_addr, 64'h44);
    repeat (2) @(negedge clk);
    check("t4_addr_stable", mem_addr, 64'h44);
    check("t4_req_stable", mem_req, 1'b1);
    redirect(64'h100);
    mem_en = 1'b1;
    check("t4_req_drop", mem_req, 1'b0);
    @(negedge clk);
    check("t4_req_wait", mem_req, 1'b0);
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    check("t4_new_req", mem_req, 1'b1);
    check("t4_new_addr", mem_addr, 64'h100);
    wait_valid("t4");
    check("t4_pc", instr_pc, 64'h100);
    check("t4_instr", instr, 80'h0);
    check("t4_no_abort", seen_bad, 1'b0);
    accept();

    // T5: illegal icode, then restart at 0
    mem[8'h50] = 8'hC0; mem[0] = 8'h10; mem[1] = 8'h00;
    redirect(64'h50);
    wait_valid("t5");
    check("t5_err", instr_err, 1'b1);
    check("t5_len", instr_len, 4'd1);
    check("t5_instr", instr, {8'hC0, 72'h0});
    accept();
    check("t5_halted", halted, 1'b1);
    redirect(64'h0);
    check("t5_unhalt", halted, 1'b0);
    wait_valid("t5b");
    check("t5b_pc", instr_pc, 64'h0);
    check("t5b_instr", instr, {8'h10, 72'h0});
    run_to_halt("t5b");

    // T6: PC wrap, then async reset mid-FETCHN
    mem[8'hFF] = 8'h61; mem[0] = 8'h23; mem[1] = 8'h00;
    redirect(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid("t6");
    check("t6_instr", instr, {8'h61, 8'h23, 64'h0});
    check("t6_len", instr_len, 4'd2);
    check("t6_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t6_wrap_rd", last_rd_addr, 64'h0);
    accept();
    check("t6_next_addr", mem_addr, 64'h1);
    check("t6_next_req", mem_req, 1'b1);
`ifdef FETCH_PERF_EN
    check("t6_perf_instr", perf_instr, 32'(accepts));
`endif
    redirect(64'h20);
    repeat (3) @(negedge clk);
    check("t6_mid_fetchn", dbg_state, 2'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_req", mem_req, 1'b0);
    check("t6_rst_addr", mem_addr, 64'h0);
    check("t6_rst_instr", instr, 80'h0);
    check("t6_rst_len", instr_len, 4'd0);
    check("t6_rst_valid", instr_valid, 1'b0);
    check("t6_rst_state", dbg_state, 2'd0);
    mem[0] = 8'h10;
    @(negedge clk);
    rst = 1'b0;
    wait_valid("t6r");
    check("t6r_pc", instr_pc, 64'h0);
    check("t6r_instr", instr, {8'h10, 72'h0});
    accept();
`ifdef FETCH_PERF_EN
    check("t6r_perf_instr", perf_instr, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
